// File: rtl/sel_ctrl_pkg.sv
// Shared types and default constants for the push-button select controller.
package sel_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int AUTO_PERIOD_DEF     = 64;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // first stage may go metastable, second stage gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sel_debounce_toggle.sv
// Push-button front end for the 2:1 data selector: synchronises and debounces
// the raw button, emits a one-cycle press pulse, and toggles sel on each press.
// Optional build macro SEL_AUTO_TOGGLE_EN adds the auto port and a free-running
// auto-toggle counter.
//
// state        | meaning
// RELEASED     | debounced level is 0, waiting for synced button high
// PRESS_WAIT   | button high, counting stable cycles before accepting a press
// HELD         | debounced level is 1, waiting for synced button low
// RELEASE_WAIT | button low, counting stable cycles before accepting release
module sel_debounce_toggle
  import sel_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic SEL_INIT        = 1'b0
`ifdef SEL_AUTO_TOGGLE_EN
  , parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
`ifdef SEL_AUTO_TOGGLE_EN
  input  logic auto,
`endif
  output logic sel,
  output logic press,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             btn_s;
  logic             accept;
  logic             toggle;

  sync_2ff u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (btn_s)
  );

  // The cycle that enters a wait state already counts as the first stable
  // cycle, so the level is accepted when the incremented count hits the last
  // value; the counter saturates rather than wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign accept  = (state == PRESS_WAIT) && btn_s && (cnt_inc == CNT_LAST);

  // debounce FSM with registered press pulse and debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RELEASED;
      cnt    <= '0;
      press  <= 1'b0;
      stable <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (accept) begin
            state  <= HELD;
            cnt    <= '0;
            press  <= 1'b1;
            stable <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_inc == CNT_LAST) begin
            state  <= RELEASED;
            cnt    <= '0;
            stable <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

`ifdef SEL_AUTO_TOGGLE_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt;
  logic              wrap;

  assign wrap = auto && (auto_cnt == AUTO_LAST);

  // auto period counter: idles at 0 when disabled, restarts on a press or wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto || accept || wrap) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  // a press landing on a wrap is a single toggle request
  assign toggle = accept | wrap;
`else
  assign toggle = accept;
`endif

  // select register flips on the same edge the press pulse rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= SEL_INIT;
    end else if (toggle) begin
      sel <= ~sel;
    end
  end

endmodule

// File: tb/tb_sel_debounce_toggle.sv
// Directed bench for sel_debounce_toggle with default parameters.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_sel_debounce_toggle;

  logic clk;
  logic rst_n;
  logic btn;
`ifdef SEL_AUTO_TOGGLE_EN
  logic auto;
`endif
  logic sel;
  logic press;
  logic stable;

  int checks;
  int errors;
  int press_cnt;
  int stable_rises;
  logic stable_q;
  int base_press;
  int base_rises;

  sel_debounce_toggle dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
`ifdef SEL_AUTO_TOGGLE_EN
    .auto   (auto),
`endif
    .sel    (sel),
    .press  (press),
    .stable (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event counters sampled mid-cycle
  initial begin
    press_cnt    = 0;
    stable_rises = 0;
    stable_q     = 1'b0;
  end
  always @(negedge clk) begin
    if (press) press_cnt++;
    if (stable && !stable_q) stable_rises++;
    stable_q = stable;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 1'b1;
`ifdef SEL_AUTO_TOGGLE_EN
    auto   = 1'b0;
`endif

    // 1: reset with button held, then full 18-edge latency to the press
    step(3);
    chk("rst_sel", int'(sel), 0);
    chk("rst_press", int'(press), 0);
    chk("rst_stable", int'(stable), 0);
    rst_n = 1'b1;
    step(17);
    chk("lat_press_e17", int'(press), 0);
    chk("lat_stable_e17", int'(stable), 0);
    step(1);
    chk("lat_press_e18", int'(press), 1);
    chk("lat_sel_e18", int'(sel), 1);
    chk("lat_stable_e18", int'(stable), 1);
    step(1);
    chk("press_width", int'(press), 0);
    btn = 1'b0;
    step(40);
    chk("release_stable", int'(stable), 0);
    chk("release_sel", int'(sel), 1);

    // 2: bounce shorter than the debounce window
    base_press = press_cnt;
    base_rises = stable_rises;
    btn = 1'b1; step(5);
    btn = 1'b0; step(3);
    btn = 1'b1; step(5);
    btn = 1'b0; step(30);
    chk("bounce_press", press_cnt - base_press, 0);
    chk("bounce_stable", stable_rises - base_rises, 0);
    chk("bounce_sel", int'(sel), 1);

    // 3: long hold gives one toggle; release takes 18 edges
    base_press = press_cnt;
    btn = 1'b1; step(200);
    chk("hold_press", press_cnt - base_press, 1);
    chk("hold_sel", int'(sel), 0);
    chk("hold_stable", int'(stable), 1);
    btn = 1'b0;
    step(17);
    chk("rel_stable_e17", int'(stable), 1);
    step(1);
    chk("rel_stable_e18", int'(stable), 0);
    step(22);
    chk("rel_sel", int'(sel), 0);

    // 4: three clean presses, sel 1,0,1
    base_press = press_cnt;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; step(30);
      chk($sformatf("seq_sel_%0d", i), int'(sel), (i % 2 == 0) ? 1 : 0);
      btn = 1'b0; step(30);
    end
    chk("seq_press", press_cnt - base_press, 3);
    chk("seq_sel_end", int'(sel), 1);

    // 5: reset mid-debounce discards the pending press
    btn = 1'b1;
    step(12);
    chk("mid_no_press", int'(stable), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_press", int'(press), 0);
    chk("mid_rst_stable", int'(stable), 0);
    step(2);
    rst_n = 1'b1;
    step(17);
    chk("mid_lat_e17", int'(press), 0);
    chk("mid_sel_e17", int'(sel), 0);
    step(1);
    chk("mid_lat_e18", int'(press), 1);
    chk("mid_sel_e18", int'(sel), 1);

`ifdef SEL_AUTO_TOGGLE_EN
    // 6: auto toggle every 64 cycles, press on a wrap is one toggle
    btn = 1'b0;
    step(40);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    auto  = 1'b1;
    step(63);
    chk("auto_e63", int'(sel), 0);
    step(1);
    chk("auto_e64", int'(sel), 1);
    step(64);
    chk("auto_e128", int'(sel), 0);
    step(46);
    btn = 1'b1;
    step(17);
    chk("auto_pw_pre", int'(sel), 0);
    step(1);
    chk("auto_pw_sel", int'(sel), 1);
    chk("auto_pw_press", int'(press), 1);
    step(63);
    chk("auto_restart_e63", int'(sel), 1);
    step(1);
    chk("auto_restart_e64", int'(sel), 0);
    auto = 1'b0;
    step(100);
    chk("auto_off_sel", int'(sel), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
